// File: rtl/ctrl_pipe.sv
// Pipelined RV32I control decoder: decodes the ID-stage opcode into a control word,
// carries it through ID/EX, EX/MEM and MEM/WB, and handles load-use stalls, flushes and perf counters.
module ctrl_pipe #(
    parameter int CTRL_WIDTH = 16,
    parameter bit EXT_EN     = 1'b1,
    parameter int PERF_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           instr_i,
    input  logic                  instr_valid_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  illegal_o,
    output logic [CTRL_WIDTH-1:0] ctrl_ex_o,
    output logic [CTRL_WIDTH-1:0] ctrl_mem_o,
    output logic [CTRL_WIDTH-1:0] ctrl_wb_o,
    output logic [4:0]            rd_ex_o,
    output logic [PERF_WIDTH-1:0] stall_cnt_o,
    output logic [PERF_WIDTH-1:0] flush_cnt_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [11:0] F_MEM_TO_REG = 12'h001;
    localparam logic [11:0] F_REG_WR     = 12'h002;
    localparam logic [11:0] F_MEM_WE     = 12'h004;
    localparam logic [11:0] F_MEM_RE     = 12'h008;
    localparam logic [11:0] F_BRANCH     = 12'h010;
    localparam logic [11:0] F_ALUSRC     = 12'h020;
    localparam logic [11:0] ALU_BRANCH   = 12'h040;
    localparam logic [11:0] ALU_FUNCT    = 12'h080;
    localparam logic [11:0] F_JUMP       = 12'h100;
    localparam logic [11:0] F_LUI        = 12'h200;
    localparam logic [11:0] F_AUIPC      = 12'h400;

    localparam int B_MEM_RE = 3;
    localparam int B_VALID  = 11;

    localparam logic [PERF_WIDTH-1:0] PERF_ONE = {{(PERF_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [PERF_WIDTH-1:0] sat_inc(input logic [PERF_WIDTH-1:0] v);
        return (&v) ? v : v + PERF_ONE;
    endfunction

    logic [6:0]            opcode;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [11:0]           dec_word;
    logic [4:0]            dec_rd;
    logic                  dec_legal;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  illegal_dec;
    logic                  hazard;
    logic                  unused_instr_bits;

    logic [CTRL_WIDTH-1:0] ctrl_p0;
    logic [CTRL_WIDTH-1:0] ctrl_p1;
    logic [CTRL_WIDTH-1:0] ctrl_p2;
    logic [4:0]            rd_p0;
    logic                  illegal_p0;
    logic [PERF_WIDTH-1:0] stall_cnt;
    logic [PERF_WIDTH-1:0] flush_cnt;

    assign opcode            = instr_i[6:0];
    assign rs1               = instr_i[19:15];
    assign rs2               = instr_i[24:20];
    assign unused_instr_bits = ^{instr_i[31:25], instr_i[14:12]};

    always_comb begin
        dec_word  = '0;
        dec_rd    = instr_i[11:7];
        dec_legal = 1'b1;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        case (opcode)
            OP_R: begin
                dec_word = ALU_FUNCT | F_ALUSRC | F_REG_WR;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_I: begin
                dec_word = ALU_FUNCT | F_REG_WR;
                uses_rs1 = 1'b1;
            end
            OP_LOAD: begin
                dec_word = F_MEM_RE | F_REG_WR | F_MEM_TO_REG;
                uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                dec_word = F_MEM_WE;
                dec_rd   = 5'd0;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                dec_legal = EXT_EN;
                dec_word  = ALU_BRANCH | F_ALUSRC | F_BRANCH;
                dec_rd    = 5'd0;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OP_JAL: begin
                dec_legal = EXT_EN;
                dec_word  = F_JUMP | F_REG_WR;
            end
            OP_JALR: begin
                dec_legal = EXT_EN;
                dec_word  = F_JUMP | F_REG_WR;
                uses_rs1  = 1'b1;
            end
            OP_LUI: begin
                dec_legal = EXT_EN;
                dec_word  = F_LUI | F_REG_WR;
            end
            OP_AUIPC: begin
                dec_legal = EXT_EN;
                dec_word  = F_AUIPC | F_REG_WR;
            end
            default: dec_legal = 1'b0;
        endcase

        if (!dec_legal) begin
            dec_word = '0;
            dec_rd   = 5'd0;
            uses_rs1 = 1'b0;
            uses_rs2 = 1'b0;
        end else begin
            dec_word[B_VALID] = instr_valid_i;
        end
        if (!instr_valid_i) begin
            dec_rd = 5'd0;
        end
    end

    assign illegal_dec = !dec_legal && instr_valid_i;

    // Load-use hazard: a load in EX writes a register the ID instruction reads
    always_comb begin
        hazard = ctrl_p0[B_VALID] && ctrl_p0[B_MEM_RE] && (rd_p0 != 5'd0)
                 && ((uses_rs1 && (rs1 == rd_p0)) || (uses_rs2 && (rs2 == rd_p0)))
                 && instr_valid_i && !flush_i;
    end

    assign stall_o = hazard;

    // ID/EX, EX/MEM, MEM/WB stage registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_p0    <= '0;
            ctrl_p1    <= '0;
            ctrl_p2    <= '0;
            rd_p0      <= 5'd0;
            illegal_p0 <= 1'b0;
        end else begin
            ctrl_p2 <= ctrl_p1;
            ctrl_p1 <= ctrl_p0;
            if (hazard || flush_i) begin
                ctrl_p0 <= '0;
                rd_p0   <= 5'd0;
            end else begin
                ctrl_p0 <= CTRL_WIDTH'(dec_word);
                rd_p0   <= dec_rd;
            end
            illegal_p0 <= illegal_dec && !flush_i && !hazard;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hazard) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (flush_i) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

    assign ctrl_ex_o   = ctrl_p0;
    assign ctrl_mem_o  = ctrl_p1;
    assign ctrl_wb_o   = ctrl_p2;
    assign rd_ex_o     = rd_p0;
    assign illegal_o   = illegal_p0;
    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;

endmodule
